// File: rtl/mem_pkg.sv
// Shared types and helpers for the data-side memory unit.
// Holds size/fault/state encodings, lane enables and load extension.
package mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'd0,
        FLT_ALIGN = 2'd1,
        FLT_MAP   = 2'd2,
        FLT_TMO   = 2'd3
    } fault_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAM_RD    = 3'd1,
        ST_RAM_EXT   = 3'd2,
        ST_MMIO_WAIT = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

    localparam logic [15:0] DEF_MMIO_PAGE = 16'hFFFF;
    localparam logic [15:0] DEF_EXC_PAGE  = 16'h1C09;

    function automatic logic [3:0] be_gen(size_e sz, logic [1:0] off);
        logic [3:0] be;
        case (sz)
            SZ_B:    be = 4'b0001 << off;
            SZ_H:    be = 4'b0011 << off;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] wdata_rep(size_e sz, logic [31:0] w);
        logic [31:0] r;
        case (sz)
            SZ_B:    r = {4{w[7:0]}};
            SZ_H:    r = {2{w[15:0]}};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(logic [31:0] w, size_e sz,
                                             logic uns, logic [1:0] off);
        logic [31:0] sh;
        logic [31:0] r;
        sh = w >> {off, 3'b000};
        case (sz)
            SZ_B:    r = uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_H:    r = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_byte_ram.sv
// Single-port word RAM with per-byte write enables and registered read.
// Contents are not reset so the array maps onto block RAM.
module mem_byte_ram #(
    parameter int DEPTH_WORDS = 16384,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data unit: decodes RAM / MMIO / fault, sizes and extends data.
// One access in flight; req_ready is high only in IDLE.
module data_mem_unit
    import mem_pkg::*;
#(
    parameter int          DEPTH_WORDS  = 16384,
    parameter logic [15:0] MMIO_PAGE    = DEF_MMIO_PAGE,
    parameter logic [15:0] EXC_PAGE     = DEF_EXC_PAGE,
    parameter int          MMIO_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic [1:0]  rsp_fault_code,
    output logic        mmio_req,
    output logic        mmio_we,
    output logic [31:0] mmio_addr,
    output logic [31:0] mmio_wdata,
    output logic [3:0]  mmio_be,
    input  logic [31:0] mmio_rdata,
    input  logic        mmio_ack
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [3:0]  TMO_LAST  = 4'(MMIO_TIMEOUT - 1);

    state_e        state_q, state_d;
    size_e         size_q, size_d;
    logic          uns_q, uns_d;
    logic [1:0]    off_q, off_d;
    logic [AW-1:0] widx_q, widx_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_fault_q, rsp_fault_d;
    fault_e        code_q, code_d;
    logic          mmio_req_q, mmio_req_d;
    logic          mmio_we_q, mmio_we_d;
    logic [31:0]   mmio_addr_q, mmio_addr_d;
    logic [31:0]   mmio_wdata_q, mmio_wdata_d;
    logic [3:0]    mmio_be_q, mmio_be_d;

    logic          accept;
    size_e         sz;
    logic          misal, is_exc, is_mmio, in_ram;
    logic [3:0]    be;
    logic [31:0]   wrep;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_rdata;

    assign accept  = req_valid && (state_q == ST_IDLE);
    assign sz      = size_e'(req_size);
    assign misal   = (req_size == 2'd3)
                   || (sz == SZ_H && req_addr[0])
                   || (sz == SZ_W && req_addr[1:0] != 2'b00);
    assign is_exc  = req_addr[31:16] == EXC_PAGE;
    assign is_mmio = req_addr[31:16] == MMIO_PAGE;
    assign in_ram  = {1'b0, req_addr} < RAM_BYTES;
    assign be      = be_gen(sz, req_addr[1:0]);
    assign wrep    = wdata_rep(sz, req_wdata);

    // Stores hit RAM on the acceptance edge; only clean RAM-path hits write
    assign ram_we   = (accept && req_we && !misal && !is_exc && !is_mmio
                       && in_ram) ? be : 4'b0000;
    assign ram_addr = (state_q == ST_IDLE) ? req_addr[AW+1:2] : widx_q;

    mem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wrep),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_d      = state_q;
        size_d       = size_q;
        uns_d        = uns_q;
        off_d        = off_q;
        widx_d       = widx_q;
        cnt_d        = cnt_q;
        rsp_rdata_d  = 32'd0;
        rsp_fault_d  = 1'b0;
        code_d       = FLT_NONE;
        mmio_req_d   = mmio_req_q;
        mmio_we_d    = mmio_we_q;
        mmio_addr_d  = mmio_addr_q;
        mmio_wdata_d = mmio_wdata_q;
        mmio_be_d    = mmio_be_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    size_d = sz;
                    uns_d  = req_unsigned;
                    off_d  = req_addr[1:0];
                    widx_d = req_addr[AW+1:2];
                    if (misal) begin
                        state_d     = ST_RESP;
                        rsp_fault_d = 1'b1;
                        code_d      = FLT_ALIGN;
                    end else if (is_exc) begin
                        state_d     = ST_RESP;
                        rsp_fault_d = 1'b1;
                        code_d      = FLT_MAP;
                    end else if (is_mmio) begin
                        state_d      = ST_MMIO_WAIT;
                        cnt_d        = 4'd0;
                        mmio_req_d   = 1'b1;
                        mmio_we_d    = req_we;
                        mmio_addr_d  = {req_addr[31:2], 2'b00};
                        mmio_wdata_d = wrep;
                        mmio_be_d    = be;
                    end else if (in_ram) begin
                        state_d = req_we ? ST_RESP : ST_RAM_RD;
                    end else begin
                        state_d     = ST_RESP;
                        rsp_fault_d = 1'b1;
                        code_d      = FLT_MAP;
                    end
                end
            end
            ST_RAM_RD: state_d = ST_RAM_EXT;
            ST_RAM_EXT: begin
                state_d     = ST_RESP;
                rsp_rdata_d = load_ext(ram_rdata, size_q, uns_q, off_q);
            end
            ST_MMIO_WAIT: begin
                // An ack on the final allowed cycle still beats the timeout
                if (mmio_ack) begin
                    state_d     = ST_RESP;
                    mmio_req_d  = 1'b0;
                    rsp_rdata_d = mmio_we_q ? 32'd0
                                : load_ext(mmio_rdata, size_q, uns_q, off_q);
                end else if (cnt_q == TMO_LAST) begin
                    state_d     = ST_RESP;
                    mmio_req_d  = 1'b0;
                    rsp_fault_d = 1'b1;
                    code_d      = FLT_TMO;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rsp_valid_d = state_d == ST_RESP;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            size_q       <= SZ_B;
            uns_q        <= 1'b0;
            off_q        <= 2'd0;
            widx_q       <= '0;
            cnt_q        <= 4'd0;
            rsp_valid_q  <= 1'b0;
            rsp_rdata_q  <= 32'd0;
            rsp_fault_q  <= 1'b0;
            code_q       <= FLT_NONE;
            mmio_req_q   <= 1'b0;
            mmio_we_q    <= 1'b0;
            mmio_addr_q  <= 32'd0;
            mmio_wdata_q <= 32'd0;
            mmio_be_q    <= 4'd0;
        end else begin
            state_q      <= state_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            off_q        <= off_d;
            widx_q       <= widx_d;
            cnt_q        <= cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_fault_q  <= rsp_fault_d;
            code_q       <= code_d;
            mmio_req_q   <= mmio_req_d;
            mmio_we_q    <= mmio_we_d;
            mmio_addr_q  <= mmio_addr_d;
            mmio_wdata_q <= mmio_wdata_d;
            mmio_be_q    <= mmio_be_d;
        end
    end

    assign req_ready      = state_q == ST_IDLE;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_fault      = rsp_fault_q;
    assign rsp_fault_code = code_q;
    assign mmio_req       = mmio_req_q;
    assign mmio_we        = mmio_we_q;
    assign mmio_addr      = mmio_addr_q;
    assign mmio_wdata     = mmio_wdata_q;
    assign mmio_be        = mmio_be_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: RAM sizes/extension, faults, MMIO
// handshake, timeout boundary and asynchronous reset abort.
module tb_data_mem_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;
    logic [1:0]  rsp_fault_code;
    logic        mmio_req;
    logic        mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [3:0]  mmio_be;
    logic [31:0] mmio_rdata;
    logic        mmio_ack;

    int n_chk  = 0;
    int n_pass = 0;

    int ack_after = -1;
    int req_cyc   = 0;
    int hi_total  = 0;
    int rsp_total = 0;
    logic [31:0] cap_addr, cap_wdata;
    logic [3:0]  cap_be;
    logic        cap_we;

    data_mem_unit #(
        .DEPTH_WORDS  (1024),
        .MMIO_TIMEOUT (15)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_fault      (rsp_fault),
        .rsp_fault_code (rsp_fault_code),
        .mmio_req       (mmio_req),
        .mmio_we        (mmio_we),
        .mmio_addr      (mmio_addr),
        .mmio_wdata     (mmio_wdata),
        .mmio_be        (mmio_be),
        .mmio_rdata     (mmio_rdata),
        .mmio_ack       (mmio_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // MMIO responder and bus monitor
    always @(negedge clk) begin
        if (rsp_valid) rsp_total++;
        if (mmio_req) begin
            hi_total++;
            cap_addr  = mmio_addr;
            cap_wdata = mmio_wdata;
            cap_be    = mmio_be;
            cap_we    = mmio_we;
        end
        if (mmio_req && !mmio_ack) begin
            req_cyc++;
            if (ack_after >= 0 && req_cyc >= ack_after) mmio_ack = 1'b1;
        end else begin
            mmio_ack = 1'b0;
            req_cyc  = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic access(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd,
                          output logic flt, output logic [1:0] code,
                          output int lat);
        int n;
        bit got;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk);
        #1 req_valid = 1'b0;
        rd   = 32'hxxxxxxxx;
        flt  = 1'bx;
        code = 2'bxx;
        got  = 1'b0;
        lat  = 0;
        while (!got && lat < 40) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin
                got  = 1'b1;
                rd   = rsp_rdata;
                flt  = rsp_fault;
                code = rsp_fault_code;
            end
        end
        if (!got) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    logic [31:0] rd;
    logic        flt;
    logic [1:0]  code;
    int          lat;
    int          hi0, rsp0;

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = 32'd0;
        req_wdata    = 32'd0;
        mmio_rdata   = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_mreq", {31'd0, mmio_req}, 32'd0);
        check("rst_be", {28'd0, mmio_be}, 32'd0);
        check("rst_code", {30'd0, rsp_fault_code}, 32'd0);
        reset = 1'b0;

        access(1, 2'd2, 0, 32'h104, 32'h55667788, rd, flt, code, lat);
        access(1, 2'd2, 0, 32'h100, 32'hDEADBEEF, rd, flt, code, lat);
        check("sw_lat", lat, 1);
        check("sw_fault", {31'd0, flt}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        access(0, 2'd0, 0, 32'h101, 32'd0, rd, flt, code, lat);
        check("lb_data", rd, 32'hFFFFFFBE);
        check("lb_lat", lat, 3);
        access(0, 2'd2, 0, 32'h104, 32'd0, rd, flt, code, lat);
        check("lw_neighbor", rd, 32'h55667788);

        access(1, 2'd1, 0, 32'h102, 32'h00001234, rd, flt, code, lat);
        access(0, 2'd2, 0, 32'h100, 32'd0, rd, flt, code, lat);
        check("lw_after_sh", rd, 32'h1234BEEF);
        access(0, 2'd1, 1, 32'h102, 32'd0, rd, flt, code, lat);
        check("lhu", rd, 32'h00001234);
        access(0, 2'd1, 0, 32'h100, 32'd0, rd, flt, code, lat);
        check("lh_signed", rd, 32'hFFFFBEEF);
        access(0, 2'd0, 1, 32'h103, 32'd0, rd, flt, code, lat);
        check("lbu_b3", rd, 32'h00000012);

        access(0, 2'd2, 0, 32'h102, 32'd0, rd, flt, code, lat);
        check("lw_mis_flt", {31'd0, flt}, 32'd1);
        check("lw_mis_code", {30'd0, code}, 32'd1);
        check("lw_mis_rd", rd, 32'd0);
        access(1, 2'd2, 0, 32'h102, 32'h0, rd, flt, code, lat);
        check("sw_mis_code", {30'd0, code}, 32'd1);
        access(1, 2'd3, 0, 32'h100, 32'h0, rd, flt, code, lat);
        check("sz3_code", {30'd0, code}, 32'd1);
        access(0, 2'd2, 0, 32'h100, 32'd0, rd, flt, code, lat);
        check("no_mis_write", rd, 32'h1234BEEF);

        hi0 = hi_total;
        access(1, 2'd2, 0, 32'h1C090000, 32'h1, rd, flt, code, lat);
        check("exc_code", {30'd0, code}, 32'd2);
        check("exc_fault", {31'd0, flt}, 32'd1);
        check("exc_no_mmio", hi_total - hi0, 0);
        access(0, 2'd2, 0, 32'h00001000, 32'd0, rd, flt, code, lat);
        check("oor_code", {30'd0, code}, 32'd2);
        access(0, 2'd2, 0, 32'h00000FFC, 32'd0, rd, flt, code, lat);
        check("last_word_ok", {31'd0, flt}, 32'd0);

        ack_after = 3;
        hi0 = hi_total;
        access(1, 2'd0, 0, 32'hFFFF0003, 32'h000000A5, rd, flt, code, lat);
        check("sb_be", {28'd0, cap_be}, 32'h8);
        check("sb_wdata", cap_wdata, 32'hA5A5A5A5);
        check("sb_addr", cap_addr, 32'hFFFF0000);
        check("sb_we", {31'd0, cap_we}, 32'd1);
        check("sb_fault", {31'd0, flt}, 32'd0);
        check("sb_lat", lat, 4);
        check("sb_hi", hi_total - hi0, 3);

        ack_after  = 1;
        mmio_rdata = 32'h11C35577;
        access(0, 2'd0, 0, 32'hFFFF0002, 32'd0, rd, flt, code, lat);
        check("mlb_data", rd, 32'hFFFFFFC3);
        check("mlb_lat", lat, 2);

        ack_after = -1;
        hi0 = hi_total;
        access(0, 2'd2, 0, 32'hFFFF0008, 32'd0, rd, flt, code, lat);
        check("tmo_hi", hi_total - hi0, 15);
        check("tmo_code", {30'd0, code}, 32'd3);
        check("tmo_rd", rd, 32'd0);
        check("tmo_lat", lat, 16);
        access(0, 2'd2, 0, 32'h100, 32'd0, rd, flt, code, lat);
        check("after_tmo", rd, 32'h1234BEEF);

        ack_after  = 15;
        mmio_rdata = 32'hCAFEF00D;
        access(0, 2'd2, 0, 32'hFFFF000C, 32'd0, rd, flt, code, lat);
        check("ack_edge_flt", {31'd0, flt}, 32'd0);
        check("ack_edge_rd", rd, 32'hCAFEF00D);

        ack_after = -1;
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = 1'b0;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_addr     = 32'hFFFF0010;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_mreq", {31'd0, mmio_req}, 32'd1);
        rsp0 = rsp_total;
        #2 reset = 1'b1;
        #1;
        check("rst_async_mreq", {31'd0, mmio_req}, 32'd0);
        check("rst_async_rdy", {31'd0, req_ready}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_no_rsp", rsp_total - rsp0, 0);
        access(0, 2'd2, 0, 32'h100, 32'd0, rd, flt, code, lat);
        check("rst_ram_kept", rd, 32'h1234BEEF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/data_mem_unit.md
Name: data_mem_unit

Overview:
- Parametrised data-side memory unit for the CPU MEM stage.
- Decodes each access into one of two paths, or rejects it:
  - internal byte-enable RAM;
  - MMIO port with request/acknowledge handshake and timeout.
  - Unmapped, protected or misaligned accesses are rejected.
- Adds byte/half/word loads and stores with sign/zero extension, alignment checks and fault reporting.
- Takes one request at a time; the pipeline stalls while req_ready is low.

Parameters:
- DEPTH_WORDS, 16384: RAM depth in 32-bit words; must be a power of two.
- MMIO_PAGE, 16'hFFFF: value of addr[31:16] that selects MMIO.
- EXC_PAGE, 16'h1C09: value of addr[31:16] of the exception-vector page. Instruction-side only; any data access to it faults.
- MMIO_TIMEOUT, 15: maximum cycles to wait for mmio_ack before faulting.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high.
- req_valid, in, 1: access request.
- req_ready, out, 1: unit idle; a request is accepted when req_valid & req_ready.
- req_we, in, 1: 1 = store, 0 = load.
- req_size, in, 2: 0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_unsigned, in, 1: zero-extend loads.
- req_addr, in, 32: byte address.
- req_wdata, in, 32: store data, right-aligned.
- rsp_valid, out, 1: single-cycle completion pulse.
- rsp_rdata, out, 32: extended load data; 0 for stores and faults.
- rsp_fault, out, 1: access rejected.
- rsp_fault_code, out, 2: 0 none, 1 misaligned/illegal size, 2 unmapped/protected, 3 MMIO timeout.
- mmio_req, out, 1: MMIO access pending; held until ack or timeout.
- mmio_we, out, 1: MMIO write.
- mmio_addr, out, 32: MMIO address, word-aligned.
- mmio_wdata, out, 32: lane-shifted store data.
- mmio_be, out, 4: MMIO byte enables.
- mmio_rdata, in, 32: MMIO read word.
- mmio_ack, in, 1: MMIO completion; sampled only while mmio_req is high.

Behaviour:
- Reset values (asynchronous):
  - state = IDLE;
  - req_ready = 1;
  - rsp_valid, rsp_fault, mmio_req, mmio_we = 0;
  - rsp_rdata, rsp_fault_code, mmio_addr, mmio_wdata, mmio_be = 0.
  - RAM contents are not cleared.
- FSM states: IDLE, RAM_RD, RAM_EXT, MMIO_WAIT, RESP.
  - req_ready = (state == IDLE).
  - rsp_valid is registered and high for exactly one cycle, in RESP. RESP returns to IDLE.
- Decode at acceptance, in priority order:
  1. req_size == 3, or half with addr[0] set, or word with addr[1:0] != 0 → fault 1.
  2. addr[31:16] == EXC_PAGE → fault 2.
  3. addr[31:16] == MMIO_PAGE → MMIO path.
  4. addr < 4*DEPTH_WORDS → RAM path.
  5. Anything else → fault 2.
- Faults go to RESP with no side effects: no RAM write, no mmio_req.
- Byte enables:
  - byte: 4'b0001 << addr[1:0];
  - half: 4'b0011 << addr[1:0];
  - word: 4'b1111.
- Write data: byte replicated to all four lanes, half replicated to both halves, word unchanged.
- RAM store: written on the acceptance edge with the byte enables → RESP. rsp_valid is high in the cycle after acceptance.
- RAM load:
  - IDLE → RAM_RD (synchronous RAM read) → RAM_EXT (lane select by the latched addr[1:0], sign/zero extend) → RESP.
  - rsp_valid is high 3 cycles after acceptance.
- MMIO access:
  - Acceptance → MMIO_WAIT. mmio_req, mmio_we, mmio_addr (addr & ~3), mmio_be and mmio_wdata are registered and held stable.
  - A 4-bit wait counter starts at 0.
  - mmio_ack seen → latch mmio_rdata, extend (loads), drop mmio_req, go to RESP.
  - Counter reaches MMIO_TIMEOUT with no ack → drop mmio_req, fault 3, go to RESP.
  - An ack in the same cycle the counter reaches its limit wins; no fault.
- Extension:
  - signed byte replicates bit 7;
  - signed half replicates bit 15;
  - unsigned fills with zeros;
  - word is passed through.
- req_valid while not ready is ignored; it is not queued.
- Reset mid-operation:
  - returns to IDLE and drops mmio_req immediately;
  - no rsp_valid is produced for the aborted access;
  - a RAM store accepted before reset is already complete.

Decomposition:
- Package mem_pkg:
  - size enum SZ_B/SZ_H/SZ_W;
  - fault code enum FLT_NONE/FLT_ALIGN/FLT_MAP/FLT_TMO;
  - FSM state enum;
  - default page constants;
  - functions for byte-enable generation and load extension.
- Sub-module mem_byte_ram: DEPTH_WORDS x 32, one port, synchronous read, 4 byte write enables, inferred block RAM.

Test Plan:
- Store word 0xDEADBEEF to 0x100, then LB 0x101 signed → RAM untouched beyond lanes 0-3; rsp_rdata = 0xFFFFFFBE, rsp_valid 3 cycles after acceptance.
- SH 0x1234 to 0x102 over 0xDEADBEEF, then LW 0x100 → 0x1234BEEF. LHU 0x102 → 0x00001234.
- LW at 0x102 → rsp_fault = 1, code 1, no RAM write. SW to 0x1C090000 → code 2. LW at 4*DEPTH_WORDS → code 2.
- SB 0xA5 to 0xFFFF0003, ack after 3 cycles → mmio_be = 4'b1000, mmio_wdata = 0xA5A5A5A5, mmio_addr = 0xFFFF0000. rsp_valid with no fault.
- MMIO load with no ack → mmio_req high for MMIO_TIMEOUT cycles, then rsp_fault code 3. A following request is accepted normally.
- Assert reset during MMIO_WAIT → mmio_req drops asynchronously, no rsp_valid, req_ready = 1. Previously stored RAM data still reads back.
